// File: rtl/vga_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 timing constants, framebuffer geometry, RGB444     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package vga_pkg;

  localparam int c_CLK_DIV = 4;

  localparam int c_H_VIS  = 640;
  localparam int c_H_FP   = 16;
  localparam int c_H_SYNC = 96;
  localparam int c_H_BP   = 48;
  localparam int c_V_VIS  = 480;
  localparam int c_V_FP   = 10;
  localparam int c_V_SYNC = 2;
  localparam int c_V_BP   = 33;

  localparam int c_HS_START = c_H_VIS + c_H_FP;            // 656
  localparam int c_HS_STOP  = c_HS_START + c_H_SYNC;       // 752
  localparam int c_H_TOTAL  = c_HS_STOP + c_H_BP;          // 800
  localparam int c_VS_START = c_V_VIS + c_V_FP;            // 490
  localparam int c_VS_STOP  = c_VS_START + c_V_SYNC;       // 492
  localparam int c_V_TOTAL  = c_VS_STOP + c_V_BP;          // 525

  localparam int c_FB_W     = 160;
  localparam int c_FB_H     = 120;
  localparam int c_SCALE_SH = 2;
  localparam int c_RGB_W    = 4;
  localparam int c_PIX_W    = 3 * c_RGB_W;
  localparam int c_ADDR_W   = 15;
  localparam int c_CNT_W    = 10;

  typedef struct packed {
    logic [c_RGB_W-1:0] r;
    logic [c_RGB_W-1:0] g;
    logic [c_RGB_W-1:0] b;
  } rgb444_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vga_timing : pixel-clock divider, h/v scan counters, raw sync/blanking  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV,
  parameter int H_VIS   = c_H_VIS,
  parameter int H_FP    = c_H_FP,
  parameter int H_SYNC  = c_H_SYNC,
  parameter int H_BP    = c_H_BP,
  parameter int V_VIS   = c_V_VIS,
  parameter int V_FP    = c_V_FP,
  parameter int V_SYNC  = c_V_SYNC,
  parameter int V_BP    = c_V_BP
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_tick,
  output logic               o_line_wrap,
  output logic [c_CNT_W-1:0] o_hcount,
  output logic [c_CNT_W-1:0] o_vcount,
  output logic               o_active,
  output logic               o_hsync_n,
  output logic               o_vsync_n,
  output logic               o_vblank
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  localparam logic [c_CNT_W-1:0] c_H_ACT_END = c_CNT_W'(H_VIS);
  localparam logic [c_CNT_W-1:0] c_HS_BEG    = c_CNT_W'(H_VIS + H_FP);
  localparam logic [c_CNT_W-1:0] c_HS_END    = c_CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [c_CNT_W-1:0] c_H_LAST    = c_CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [c_CNT_W-1:0] c_V_ACT_END = c_CNT_W'(V_VIS);
  localparam logic [c_CNT_W-1:0] c_VS_BEG    = c_CNT_W'(V_VIS + V_FP);
  localparam logic [c_CNT_W-1:0] c_VS_END    = c_CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [c_CNT_W-1:0] c_V_LAST    = c_CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [c_CNT_W-1:0] r_hcount;
  logic [c_CNT_W-1:0] r_vcount;
  logic               w_tick;
  logic               w_h_last;

  assign w_tick   = (r_div == c_DIV_LAST);
  assign w_h_last = (r_hcount == c_H_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div    <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        // Horizontal wrap and vertical step share one tick so both land together.
        if (w_h_last) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == c_V_LAST) ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
    end
  end

  assign o_tick      = w_tick;
  assign o_line_wrap = w_tick && w_h_last;
  assign o_hcount    = r_hcount;
  assign o_vcount    = r_vcount;
  assign o_active    = (r_hcount < c_H_ACT_END) && (r_vcount < c_V_ACT_END);
  assign o_hsync_n   = !((r_hcount >= c_HS_BEG) && (r_hcount < c_HS_END));
  assign o_vsync_n   = !((r_vcount >= c_VS_BEG) && (r_vcount < c_VS_END));
  assign o_vblank    = (r_vcount >= c_V_ACT_END);

endmodule
`default_nettype wire

// File: rtl/vga_frame_scanner.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vga_frame_scanner : 640x480 VGA scan-out of a 160x120 RGB444 framebuffer|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV,
  parameter int H_VIS   = c_H_VIS,
  parameter int H_FP    = c_H_FP,
  parameter int H_SYNC  = c_H_SYNC,
  parameter int H_BP    = c_H_BP,
  parameter int V_VIS   = c_V_VIS,
  parameter int V_FP    = c_V_FP,
  parameter int V_SYNC  = c_V_SYNC,
  parameter int V_BP    = c_V_BP,
  parameter int FB_W    = c_FB_W,
  parameter int FB_H    = c_FB_H
) (
  input  logic                clock,
  input  logic                reset,
  output logic [c_ADDR_W-1:0] fb_addr,
  input  logic [c_PIX_W-1:0]  fb_data,
  output logic                hSync,
  output logic                vSync,
  output logic [c_RGB_W-1:0]  VGA_R,
  output logic [c_RGB_W-1:0]  VGA_G,
  output logic [c_RGB_W-1:0]  VGA_B,
  output logic                frame_start,
  output logic                vblank
);

  // The shift-add row multiply below is hard-wired for a 160-wide buffer.
  if (FB_W != 160 || (FB_W * FB_H) > (1 << c_ADDR_W)) begin : g_fb_geometry_bad
    $error("vga_frame_scanner: framebuffer geometry not supported");
  end

  localparam logic [c_CNT_W-1:0] c_V_LAST_VIS = c_CNT_W'(V_VIS - 1);

  logic               w_tick;
  logic               w_line_wrap;
  logic               w_active;
  logic               w_hsync_n;
  logic               w_vsync_n;
  logic [c_CNT_W-1:0] w_hcount;
  logic [c_CNT_W-1:0] w_vcount;
  logic [c_CNT_W-1:0] w_row;
  logic [c_CNT_W-1:0] w_col;

  rgb444_t r_rgb;
  logic    r_hsync_n;
  logic    r_vsync_n;
  logic    r_frame_start;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .o_tick      (w_tick),
    .o_line_wrap (w_line_wrap),
    .o_hcount    (w_hcount),
    .o_vcount    (w_vcount),
    .o_active    (w_active),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_vblank    (vblank)
  );

  assign w_row   = w_vcount >> c_SCALE_SH;
  assign w_col   = w_hcount >> c_SCALE_SH;
  // row*160 = row*128 + row*32
  assign fb_addr = w_active
                 ? ((c_ADDR_W'(w_row) << 7) + (c_ADDR_W'(w_row) << 5) + c_ADDR_W'(w_col))
                 : '0;

  // The address is held for a whole pixel, so fb_data on the tick belongs to
  // the current counters; gating with the current active bit and registering
  // sync alongside keeps colour and sync one pixel late and aligned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rgb         <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_line_wrap && (w_vcount == c_V_LAST_VIS);
      if (w_tick) begin
        r_rgb     <= w_active ? rgb444_t'(fb_data) : '0;
        r_hsync_n <= w_hsync_n;
        r_vsync_n <= w_vsync_n;
      end
    end
  end

  assign VGA_R       = r_rgb.r;
  assign VGA_G       = r_rgb.g;
  assign VGA_B       = r_rgb.b;
  assign hSync       = r_hsync_n;
  assign vSync       = r_vsync_n;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_scanner.sv
`default_nettype none
// Bench for vga_frame_scanner: full-width lines, 13-line frame
// (10 visible, 1 front porch, 2 sync) so whole frames fit in a short run.
module tb_vga_frame_scanner;

  localparam int V_VIS  = 10;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 0;
  localparam int LINE_CLKS  = 3200;
  localparam int FRAME_CLKS = (V_VIS + V_FP + V_SYNC + V_BP) * LINE_CLKS;  // 41600

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [14:0] fb_addr;
  logic [11:0] fb_data = 12'h000;
  logic        hSync, vSync, frame_start, vblank;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        ram_mode = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc;

  vga_frame_scanner #(
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .hSync       (hSync),
    .vSync       (vSync),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  always #5 clock = ~clock;

  // Framebuffer model: synchronous read, either a solid colour or data = address.
  always @(posedge clock) fb_data <= ram_mode ? fb_addr[11:0] : 12'hF0A;

  // Clock edges since the last reset release.
  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  int fs_n, vb_n, vs_low;
  int fs_cyc [4];
  int vb_cyc [4];
  logic prev_vb;

  always @(negedge clock) begin
    if (!reset) begin
      fs_n = 0; vb_n = 0; vs_low = 0; prev_vb = 1'b0;
    end else begin
      if (frame_start) begin
        if (fs_n < 4) fs_cyc[fs_n] = cyc;
        fs_n++;
      end
      if (vblank && !prev_vb) begin
        if (vb_n < 4) vb_cyc[vb_n] = cyc;
        vb_n++;
      end
      if (!vSync) vs_low++;
      prev_vb = vblank;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 100000) begin
      @(negedge clock);
      g++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: reached %0d, expected %0d", cyc, n);
    end
  endtask

  // One scan line from reset release with solid colour F0A.
  task automatic measure_line(input string tag);
    int n_rgb = 0, first_rgb = -1, n_hs = 0, first_hs = -1, n_vbad = 0, g = 0;
    while (cyc < LINE_CLKS && g < LINE_CLKS + 10) begin
      if ({VGA_R, VGA_G, VGA_B} == 12'hF0A) begin
        n_rgb++;
        if (first_rgb < 0) first_rgb = cyc;
      end
      if (!hSync) begin
        n_hs++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (!vSync || vblank) n_vbad++;
      @(negedge clock);
      g++;
    end
    chk({tag, " first_pixel_clk"}, first_rgb, 4);
    chk({tag, " rgb_clks"},        n_rgb,     2560);
    chk({tag, " hsync_low_clks"},  n_hs,      384);
    chk({tag, " hsync_offset"},    first_hs - first_rgb, 2624);
    chk({tag, " vsync_vblank_bad"}, n_vbad,   0);
  endtask

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // sample clock = 4*(y*800+x)+1; pins show pixel x-1; RAM data = address
    vecs[0]  = '{10001, 15'd25,  12'h018, 1'b1, 1'b1, 1'b0};  // (100,3)
    vecs[1]  = '{12801, 15'd160, 12'h000, 1'b1, 1'b1, 1'b0};  // (0,4)
    vecs[2]  = '{12805, 15'd160, 12'h0A0, 1'b1, 1'b1, 1'b0};  // (1,4)
    vecs[3]  = '{16021, 15'd161, 12'h0A1, 1'b1, 1'b1, 1'b0};  // (5,5)
    vecs[4]  = '{28829, 15'd321, 12'h141, 1'b1, 1'b1, 1'b0};  // (7,9)
    vecs[5]  = '{28833, 15'd322, 12'h141, 1'b1, 1'b1, 1'b0};  // (8,9)
    vecs[6]  = '{31357, 15'd479, 12'h1DF, 1'b1, 1'b1, 1'b0};  // (639,9)
    vecs[7]  = '{31361, 15'd0,   12'h1DF, 1'b1, 1'b1, 1'b0};  // (640,9)
    vecs[8]  = '{31365, 15'd0,   12'h000, 1'b1, 1'b1, 1'b0};  // (641,9)
    vecs[9]  = '{31425, 15'd0,   12'h000, 1'b1, 1'b1, 1'b0};  // (656,9)
    vecs[10] = '{31429, 15'd0,   12'h000, 1'b0, 1'b1, 1'b0};  // (657,9)
    vecs[11] = '{31809, 15'd0,   12'h000, 1'b0, 1'b1, 1'b0};  // (752,9)
    vecs[12] = '{31813, 15'd0,   12'h000, 1'b1, 1'b1, 1'b0};  // (753,9)
    vecs[13] = '{32001, 15'd0,   12'h000, 1'b1, 1'b1, 1'b1};  // (0,10)
    vecs[14] = '{35201, 15'd0,   12'h000, 1'b1, 1'b1, 1'b1};  // (0,11)
    vecs[15] = '{35205, 15'd0,   12'h000, 1'b1, 1'b0, 1'b1};  // (1,11)
    vecs[16] = '{41601, 15'd0,   12'h000, 1'b1, 1'b0, 1'b0};  // (0,0) next frame
    vecs[17] = '{41605, 15'd0,   12'h000, 1'b1, 1'b1, 1'b0};  // (1,0)
    vecs[18] = '{41621, 15'd1,   12'h001, 1'b1, 1'b1, 1'b0};  // (5,0)

    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("por hSync",       hSync, 1);
    chk("por vSync",       vSync, 1);
    chk("por rgb",         {VGA_R, VGA_G, VGA_B}, 0);
    chk("por frame_start", frame_start, 0);
    chk("por vblank",      vblank, 0);
    chk("por fb_addr",     fb_addr, 0);
    reset = 1'b1;
    measure_line("por");

    // Reset in the middle of visible line 2, pixel 100.
    wait_cyc(6801);
    chk("pre rgb",     {VGA_R, VGA_G, VGA_B}, 12'hF0A);
    chk("pre fb_addr", fb_addr, 25);
    reset = 1'b0;
    #1;
    chk("mid hSync",       hSync, 1);
    chk("mid vSync",       vSync, 1);
    chk("mid rgb",         {VGA_R, VGA_G, VGA_B}, 0);
    chk("mid frame_start", frame_start, 0);
    chk("mid fb_addr",     fb_addr, 0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    measure_line("mid");

    ram_mode = 1'b1;
    for (int i = 0; i < 19; i++) begin
      wait_cyc(vecs[i].cyc);
      chk($sformatf("vec%0d fb_addr", i), fb_addr, vecs[i].addr);
      chk($sformatf("vec%0d rgb", i),     {VGA_R, VGA_G, VGA_B}, vecs[i].rgb);
      chk($sformatf("vec%0d hSync", i),   hSync, vecs[i].hs);
      chk($sformatf("vec%0d vSync", i),   vSync, vecs[i].vs);
      chk($sformatf("vec%0d vblank", i),  vblank, vecs[i].vb);
    end

    // Two frame boundaries: exact timing, single-clock pulses, sync length.
    wait_cyc(32000 + FRAME_CLKS + 5);
    chk("fs count",          fs_n, 2);
    chk("fs first clk",      fs_cyc[0], 32000);
    chk("fs period",         fs_cyc[1] - fs_cyc[0], FRAME_CLKS);
    chk("vblank rise count", vb_n, 2);
    chk("fs vs vblank 0",    vb_cyc[0], fs_cyc[0]);
    chk("fs vs vblank 1",    vb_cyc[1], fs_cyc[1]);
    chk("vsync low clks",    vs_low, 2 * LINE_CLKS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
